// File: rtl/pipeline_step_ctrl.sv
// Step/run controller: turns debug commands into the pipeline advance enable and counts executed cycles.
// Optional breakpoint support is compiled in with `define BREAKPOINT_EN.
module pipeline_step_ctrl #(
  parameter int NB        = 32,
  parameter int NB_CYCLES = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic [NB-1:0]        i_pc,
  input  logic                 i_halt_detected,
  input  logic                 i_bp_set,
  input  logic [NB-1:0]        i_bp_addr,
  output logic                 o_step,
  output logic [1:0]           o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count,
  output logic                 o_done_pulse,
  output logic                 o_bp_hit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  state_t state;
  logic   cmd_acc;
  logic   bp_match;

  // Enable and ready are pure decodes of the state register, so no input reaches them combinationally.
  assign o_step      = (state == S_RUN) || (state == S_STEP);
  assign o_cmd_ready = (state != S_STEP);
  assign o_state     = state;
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;

`ifdef BREAKPOINT_EN
  logic [NB-1:0] bp_reg;
  logic          bp_valid;
  logic          run_first;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bp_reg    <= '0;
      bp_valid  <= 1'b0;
      run_first <= 1'b0;
    end else begin
      if (i_bp_set) begin
        bp_reg   <= i_bp_addr;
        bp_valid <= 1'b1;
      end
      // Marks the first RUN cycle so resuming at the breakpoint PC does not re-trap.
      run_first <= (state == S_IDLE) && cmd_acc && (i_cmd == CMD_RUN);
    end
  end

  assign bp_match = bp_valid && !run_first && (i_pc == bp_reg);
`else
  logic unused_bp;
  assign unused_bp = ^{i_bp_set, i_bp_addr, i_pc};
  assign bp_match  = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_IDLE;
      o_cycle_count <= '0;
      o_done_pulse  <= 1'b0;
      o_bp_hit      <= 1'b0;
    end else begin
      o_done_pulse <= 1'b0;
      o_bp_hit     <= 1'b0;
      if (o_step && (o_cycle_count != '1))
        o_cycle_count <= o_cycle_count + 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_acc) begin
            case (i_cmd)
              CMD_RUN:   state <= S_RUN;
              CMD_STEP:  state <= S_STEP;
              CMD_CLEAR: o_cycle_count <= '0;
              default:   ;
            endcase
          end
        end
        S_RUN: begin
          // halt > breakpoint > pause
          if (i_halt_detected) begin
            state        <= S_DONE;
            o_done_pulse <= 1'b1;
          end else if (bp_match) begin
            state    <= S_IDLE;
            o_bp_hit <= 1'b1;
          end else if (cmd_acc && (i_cmd == CMD_PAUSE)) begin
            state <= S_IDLE;
          end
        end
        S_STEP: begin
          if (i_halt_detected) begin
            state        <= S_DONE;
            o_done_pulse <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (cmd_acc && (i_cmd == CMD_CLEAR)) begin
            state         <= S_IDLE;
            o_cycle_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Bench for pipeline_step_ctrl: directed scenarios plus random commands against a cycle-level reference model.
module tb_pipeline_step_ctrl;
  localparam int NB   = 32;
  localparam int NBC  = 4;
  localparam int CMAX = (1 << NBC) - 1;

  logic           i_clk = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_cmd_valid = 1'b0;
  logic [1:0]     i_cmd = 2'b00;
  logic           o_cmd_ready;
  logic [NB-1:0]  i_pc = '0;
  logic           i_halt_detected = 1'b0;
  logic           i_bp_set = 1'b0;
  logic [NB-1:0]  i_bp_addr = '0;
  logic           o_step;
  logic [1:0]     o_state;
  logic [NBC-1:0] o_cycle_count;
  logic           o_done_pulse;
  logic           o_bp_hit;

  pipeline_step_ctrl #(.NB(NB), .NB_CYCLES(NBC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_pc(i_pc), .i_halt_detected(i_halt_detected),
    .i_bp_set(i_bp_set), .i_bp_addr(i_bp_addr), .o_step(o_step), .o_state(o_state),
    .o_cycle_count(o_cycle_count), .o_done_pulse(o_done_pulse), .o_bp_hit(o_bp_hit)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 running, 2 single step, 3 done (matches the o_state code).
  int          m_mode;
  int          m_cnt;
  logic [31:0] m_pc;
  logic [31:0] m_bp;
  bit          m_bpv;
  bit          m_first;
  bit          m_done;
  bit          m_bph;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pc = 0; m_bp = 0;
    m_bpv = 0; m_first = 0; m_done = 0; m_bph = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] c, input bit h,
                            input bit bs, input logic [31:0] ba);
    bit stepping;
    bit acc;
    bit bp_now;
    int nxt;
    stepping = (m_mode == 1) || (m_mode == 2);
    acc      = v && (m_mode != 2);
    bp_now   = 0;
`ifdef BREAKPOINT_EN
    bp_now   = m_bpv && !m_first && (m_pc == m_bp);
`endif
    nxt    = m_mode;
    m_done = 0;
    m_bph  = 0;
    if (stepping && m_cnt < CMAX) m_cnt++;
    case (m_mode)
      0: if (acc) begin
           if (c == 2'd1) nxt = 1;
           else if (c == 2'd2) nxt = 2;
           else if (c == 2'd0) m_cnt = 0;
         end
      1: if (h) begin nxt = 3; m_done = 1; end
         else if (bp_now) begin nxt = 0; m_bph = 1; end
         else if (acc && c == 2'd3) nxt = 0;
      2: if (h) begin nxt = 3; m_done = 1; end
         else nxt = 0;
      default: if (acc && c == 2'd0) begin nxt = 0; m_cnt = 0; end
    endcase
    m_first = (m_mode == 0) && (nxt == 1);
    if (stepping) m_pc += 4;
    if (bs) begin m_bpv = 1; m_bp = ba; end
    m_mode = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".step"},  o_step,        (m_mode == 1 || m_mode == 2));
    chk({tag, ".state"}, o_state,       m_mode);
    chk({tag, ".count"}, o_cycle_count, m_cnt);
    chk({tag, ".ready"}, o_cmd_ready,   (m_mode != 2));
    chk({tag, ".done"},  o_done_pulse,  m_done);
`ifdef BREAKPOINT_EN
    chk({tag, ".bphit"}, o_bp_hit,      m_bph);
`else
    chk({tag, ".bphit"}, o_bp_hit,      1'b0);
`endif
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic cyc(input string tag, input bit v, input logic [1:0] c, input bit h,
                     input bit bs, input logic [31:0] ba);
    i_cmd_valid = v; i_cmd = c; i_halt_detected = h;
    i_bp_set = bs; i_bp_addr = ba; i_pc = m_pc;
    @(posedge i_clk);
    model_step(v, c, h, bs, ba);
    @(negedge i_clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 2'd0, 0, 0, 32'h0);
  endtask

  int steps_seen;
  bit hit_seen;

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    check_all("reset");

    // 1: quiet after reset
    for (int i = 0; i < 10; i++) idle("t1");

    // 2: three single steps
    steps_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("t2_cmd", 1, 2'd2, 0, 0, 32'h0);
      if (o_step) steps_seen++;
      idle("t2_gap");
      if (o_step) steps_seen++;
    end
    chk("t2_steps", steps_seen, 3);
    chk("t2_cnt", o_cycle_count, 3);

    // 3: run five cycles then pause
    cyc("t3_clr", 1, 2'd0, 0, 0, 32'h0);
    cyc("t3_run", 1, 2'd1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) idle("t3");
    cyc("t3_pause", 1, 2'd3, 0, 0, 32'h0);
    chk("t3_cnt", o_cycle_count, 5);
    chk("t3_state", o_state, 2'b00);

    // 4: halt and pause on the same edge, halt wins
    cyc("t4_clr", 1, 2'd0, 0, 0, 32'h0);
    cyc("t4_run", 1, 2'd1, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) idle("t4");
    cyc("t4_halt", 1, 2'd3, 1, 0, 32'h0);
    chk("t4_state", o_state, 2'b11);
    chk("t4_cnt", o_cycle_count, 7);
    chk("t4_pulse", o_done_pulse, 1'b1);
    idle("t4_hold");
    cyc("t4_run_ign", 1, 2'd1, 0, 0, 32'h0);
    cyc("t4_clear", 1, 2'd0, 0, 0, 32'h0);
    chk("t4_cnt0", o_cycle_count, 0);

    // 5: asynchronous reset in the middle of a run
    cyc("t5_run", 1, 2'd1, 0, 0, 32'h0);
    idle("t5");
    idle("t5");
    i_cmd_valid = 0; i_halt_detected = 0; i_bp_set = 0; i_pc = m_pc;
    @(posedge i_clk);
    model_step(0, 2'd0, 0, 0, 32'h0);
    #2 i_reset = 1'b1;
    #1;
    chk("t5_step", o_step, 1'b0);
    chk("t5_cnt", o_cycle_count, 0);
    chk("t5_state", o_state, 2'b00);
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    check_all("t5_after");

`ifdef BREAKPOINT_EN
    // 6: breakpoint stop and clean resume
    cyc("t6_set", 0, 2'd0, 0, 1, 32'h10);
    cyc("t6_run", 1, 2'd1, 0, 0, 32'h0);
    hit_seen = 0;
    for (int i = 0; i < 20 && !hit_seen; i++) begin
      idle("t6");
      if (o_bp_hit) hit_seen = 1;
    end
    chk("t6_hit_seen", hit_seen, 1'b1);
    chk("t6_state", o_state, 2'b00);
    cyc("t6_resume", 1, 2'd1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) idle("t6_run2");
    cyc("t6_pause", 1, 2'd3, 0, 0, 32'h0);
`endif

    // saturation of the cycle counter
    cyc("sat_clr", 1, 2'd0, 0, 0, 32'h0);
    cyc("sat_run", 1, 2'd1, 0, 0, 32'h0);
    for (int i = 0; i < CMAX + 5; i++) idle("sat");
    chk("sat_cnt", o_cycle_count, CMAX);
    cyc("sat_pause", 1, 2'd3, 0, 0, 32'h0);

    // random commands, halts and breakpoint loads
    for (int i = 0; i < 400; i++) begin
      bit v, h, bs;
      logic [1:0] c;
      logic [31:0] ba;
      v  = ($urandom_range(0, 1) == 1);
      c  = 2'($urandom_range(0, 3));
      h  = ($urandom_range(0, 19) == 0);
      bs = ($urandom_range(0, 15) == 0);
      ba = m_pc + 32'(4 * $urandom_range(0, 8));
      cyc("rnd", v, c, h, bs, ba);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
